// File: rtl/scsi_sm_input_cond.sv
// ---------------------------------------------------------------------------
// scsi_sm_input_cond
//   Input-conditioning stage in front of the SCSI state-machine input decode.
//   It synchronises the asynchronous DREQ_/DSACK_ handshake lines, detects
//   the synchronised assertion of DSACK_, holds the pending CPU-access
//   request flag, and keeps the 2-bit longword byte-offset pointer.
//
// Parameters
//   SYNC_STAGES  depth of each DREQ_/DSACK_ synchroniser (2 or 3 only)
//
// Ports
//   CLK, RST      clock and synchronous active-high reset
//   DREQ_, DSACK_ async active-low SCSI controller handshake inputs
//   SET_CPUREQ    host CPU-access request pulse
//   CLR_CPUREQ    CPU access serviced pulse from the SCSI SM
//   CLRBO, LOADBO, BO_IN, INCBO   byte-offset clear / load / increment
//   CDREQ_, CDSACK_  synchronised handshake lines (active-low)
//   DSACK_FALL    one-cycle pulse on synchronised DSACK_ assertion
//   CCPUREQ       registered pending CPU-request flag
//   BO, BOEQ3     current byte offset and its ==3 decode
// ---------------------------------------------------------------------------
module scsi_sm_input_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DREQ_,
    input  logic       DSACK_,
    input  logic       SET_CPUREQ,
    input  logic       CLR_CPUREQ,
    input  logic       CLRBO,
    input  logic       LOADBO,
    input  logic [1:0] BO_IN,
    input  logic       INCBO,
    output logic       CDREQ_,
    output logic       CDSACK_,
    output logic       DSACK_FALL,
    output logic       CCPUREQ,
    output logic [1:0] BO,
    output logic       BOEQ3
);

    // Only 2- and 3-stage synchronisers are supported; anything else must
    // stop elaboration rather than build an unverified chain.
    generate
        if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_stages
            $error("scsi_sm_input_cond: SYNC_STAGES must be 2 or 3");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cpu_state_e;

    logic [SYNC_STAGES-1:0] dreq_sync_q,  dreq_sync_d;
    logic [SYNC_STAGES-1:0] dsack_sync_q, dsack_sync_d;
    logic                   dsack_prev_q, dsack_prev_d;
    cpu_state_e             cpu_state_q,  cpu_state_d;
    logic [1:0]             bo_q,         bo_d;

    always_comb begin
        // Bit 0 is the capture stage; the MSB is the settled output stage.
        dreq_sync_d  = {dreq_sync_q[SYNC_STAGES-2:0],  DREQ_};
        dsack_sync_d = {dsack_sync_q[SYNC_STAGES-2:0], DSACK_};
        dsack_prev_d = dsack_sync_q[SYNC_STAGES-1];

        // Set has priority over clear so a request arriving in the same
        // cycle as the service acknowledge is never dropped.
        cpu_state_d = cpu_state_q;
        case (cpu_state_q)
            IDLE:    if (SET_CPUREQ) cpu_state_d = PEND;
            PEND:    if (CLR_CPUREQ && !SET_CPUREQ) cpu_state_d = IDLE;
            default: cpu_state_d = IDLE;
        endcase

        bo_d = bo_q;
        if (CLRBO)       bo_d = 2'd0;
        else if (LOADBO) bo_d = BO_IN;
        else if (INCBO)  bo_d = bo_q + 2'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Chains reset to the deasserted (high) level; the previous
            // DSACK_ value resets high too, so no edge is seen right after
            // reset even if DSACK_ is already low.
            dreq_sync_q  <= '1;
            dsack_sync_q <= '1;
            dsack_prev_q <= 1'b1;
            cpu_state_q  <= IDLE;
            bo_q         <= 2'd0;
        end else begin
            dreq_sync_q  <= dreq_sync_d;
            dsack_sync_q <= dsack_sync_d;
            dsack_prev_q <= dsack_prev_d;
            cpu_state_q  <= cpu_state_d;
            bo_q         <= bo_d;
        end
    end

    assign CDREQ_     = dreq_sync_q[SYNC_STAGES-1];
    assign CDSACK_    = dsack_sync_q[SYNC_STAGES-1];
    // Both terms are flops, so the pulse is glitch-free and has no path
    // from the asynchronous input.
    assign DSACK_FALL = dsack_prev_q & ~CDSACK_;
    assign CCPUREQ    = (cpu_state_q == PEND);
    assign BO         = bo_q;
    assign BOEQ3      = &bo_q;

endmodule

// File: tb/tb_scsi_sm_input_cond.sv
module tb_scsi_sm_input_cond;

    logic       CLK = 1'b0;
    logic       RST, DREQ_, DSACK_, SET_CPUREQ, CLR_CPUREQ, CLRBO, LOADBO, INCBO;
    logic [1:0] BO_IN;

    logic       cdreq2, cdsack2, fall2, cpu2, boeq2;
    logic [1:0] bo2;
    logic       cdreq3, cdsack3, fall3, cpu3, boeq3;
    logic [1:0] bo3;

    always #5 CLK = ~CLK;

    scsi_sm_input_cond #(.SYNC_STAGES(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .DREQ_(DREQ_), .DSACK_(DSACK_),
        .SET_CPUREQ(SET_CPUREQ), .CLR_CPUREQ(CLR_CPUREQ),
        .CLRBO(CLRBO), .LOADBO(LOADBO), .BO_IN(BO_IN), .INCBO(INCBO),
        .CDREQ_(cdreq2), .CDSACK_(cdsack2), .DSACK_FALL(fall2),
        .CCPUREQ(cpu2), .BO(bo2), .BOEQ3(boeq2));

    scsi_sm_input_cond #(.SYNC_STAGES(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .DREQ_(DREQ_), .DSACK_(DSACK_),
        .SET_CPUREQ(SET_CPUREQ), .CLR_CPUREQ(CLR_CPUREQ),
        .CLRBO(CLRBO), .LOADBO(LOADBO), .BO_IN(BO_IN), .INCBO(INCBO),
        .CDREQ_(cdreq3), .CDSACK_(cdsack3), .DSACK_FALL(fall3),
        .CCPUREQ(cpu3), .BO(bo3), .BOEQ3(boeq3));

    // Observed vector: {cdreq(3-stage), cdreq, cdsack, fall, ccpureq, bo[1:0], boeq3}
    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_DREQ = 8'hC0;
    localparam logic [7:0] M_CPU  = 8'h08;
    localparam logic [7:0] M_BO   = 8'h07;

    typedef struct {
        string      tag;
        logic [7:0] mask;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] ev(input logic r3, input logic r2, input logic s,
                                      input logic f, input logic c, input logic [1:0] b,
                                      input logic z);
        return {r3, r2, s, f, c, b, z};
    endfunction

    // Monitor: one expectation per clock, checked just after the edge.
    always @(posedge CLK) begin
        #1;
        if (q.size() != 0) begin
            exp_t       it;
            logic [7:0] act;
            it  = q.pop_front();
            act = {cdreq3, cdreq2, cdsack2, fall2, cpu2, bo2, boeq2};
            if (it.mask != 8'h00) begin
                n_cmp++;
                if ((act & it.mask) !== (it.exp & it.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b (mask %b) t=%0t",
                             it.tag, act, it.exp, it.mask, $time);
                end
            end
        end
    end

    // Inputs are already applied; queue the expectation for the coming edge.
    task automatic step(input string tag, input logic [7:0] mask, input logic [7:0] exp);
        exp_t it;
        it.tag = tag; it.mask = mask; it.exp = exp;
        q.push_back(it);
        @(negedge CLK);
    endtask

    // Hold DREQ_ at v for n cycles coming from previous level p.
    task automatic dreq_seg(input string tag, input logic p, input logic v,
                            input int n, input int off);
        #(off);
        DREQ_ = v;
        for (int i = 0; i < n; i++) begin
            step(tag, M_DREQ, {(i >= 2) ? v : p, (i >= 1) ? v : p, 6'b0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic lvl;
        RST = 1'b1; DREQ_ = 1'b0; DSACK_ = 1'b0; SET_CPUREQ = 1'b0; CLR_CPUREQ = 1'b0;
        CLRBO = 1'b0; LOADBO = 1'b0; BO_IN = 2'd0; INCBO = 1'b0;
        @(negedge CLK);

        // 1: reset with inputs low, then release
        step("rst_a", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        step("rst_b", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        RST = 1'b0;
        step("rel_e0", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        step("rel_e1", M_ALL, ev(1, 0, 0, 1, 0, 2'd0, 0));
        step("rel_e2", M_ALL, ev(0, 0, 0, 0, 0, 2'd0, 0));
        step("rel_hold", M_ALL, ev(0, 0, 0, 0, 0, 2'd0, 0));
        step("rel_hold", M_ALL, ev(0, 0, 0, 0, 0, 2'd0, 0));

        // 2: DREQ_ 1->0->1, 5 cycles each, then jittered segments
        dreq_seg("dreq_hi", 1'b0, 1'b1, 5, 0);
        dreq_seg("dreq_lo", 1'b1, 1'b0, 5, 0);
        dreq_seg("dreq_hi2", 1'b0, 1'b1, 5, 0);
        lvl = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dreq_seg("dreq_jit", lvl, ~lvl, $urandom_range(3, 6), $urandom_range(0, 3));
            lvl = ~lvl;
        end
        dreq_seg("dreq_park", lvl, 1'b1, 4, 0);

        // 3: CPU-request flag
        SET_CPUREQ = 1'b1;
        step("cpu_set", M_CPU, 8'h08);
        SET_CPUREQ = 1'b0;
        for (int i = 0; i < 10; i++) step("cpu_hold", M_CPU, 8'h08);
        CLR_CPUREQ = 1'b1;
        step("cpu_clr", M_CPU, 8'h00);
        step("cpu_clr_idle", M_CPU, 8'h00);
        SET_CPUREQ = 1'b1;
        step("cpu_both_idle", M_CPU, 8'h08);
        step("cpu_both_pend", M_CPU, 8'h08);
        SET_CPUREQ = 1'b0; CLR_CPUREQ = 1'b0;
        step("cpu_after_both", M_CPU, 8'h08);
        SET_CPUREQ = 1'b1;
        step("cpu_set_pend", M_CPU, 8'h08);
        SET_CPUREQ = 1'b0;
        step("cpu_keep", M_CPU, 8'h08);

        // 4: INCBO for six cycles from 0
        INCBO = 1'b1;
        step("bo_inc1", M_BO, ev(0, 0, 0, 0, 0, 2'd1, 0));
        step("bo_inc2", M_BO, ev(0, 0, 0, 0, 0, 2'd2, 0));
        step("bo_inc3", M_BO, ev(0, 0, 0, 0, 0, 2'd3, 1));
        step("bo_wrap", M_BO, ev(0, 0, 0, 0, 0, 2'd0, 0));
        step("bo_inc5", M_BO, ev(0, 0, 0, 0, 0, 2'd1, 0));
        step("bo_inc6", M_BO, ev(0, 0, 0, 0, 0, 2'd2, 0));
        INCBO = 1'b0;
        step("bo_hold", M_BO, ev(0, 0, 0, 0, 0, 2'd2, 0));

        // 5: priority CLRBO > LOADBO > INCBO
        INCBO = 1'b1; LOADBO = 1'b1; BO_IN = 2'd2;
        step("bo_load_over_inc", M_BO, ev(0, 0, 0, 0, 0, 2'd2, 0));
        CLRBO = 1'b1; BO_IN = 2'd3;
        step("bo_clr_over_all", M_BO, ev(0, 0, 0, 0, 0, 2'd0, 0));
        CLRBO = 1'b0; INCBO = 1'b0;
        step("bo_load3", M_BO, ev(0, 0, 0, 0, 0, 2'd3, 1));
        LOADBO = 1'b0;
        step("bo_hold3", M_BO, ev(0, 0, 0, 0, 0, 2'd3, 1));

        // 6: reset mid-operation (BO=3, CCPUREQ=1, DSACK_ low), with
        // SET_CPUREQ and INCBO active to show reset priority
        step("pre_rst", M_ALL, ev(1, 1, 0, 0, 1, 2'd3, 1));
        RST = 1'b1; SET_CPUREQ = 1'b1; INCBO = 1'b1;
        step("mid_rst", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        RST = 1'b0; SET_CPUREQ = 1'b0; INCBO = 1'b0;
        step("mid_rel_e0", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        step("mid_rel_e1", M_ALL, ev(1, 1, 0, 1, 0, 2'd0, 0));
        step("mid_rel_e2", M_ALL, ev(1, 1, 0, 0, 0, 2'd0, 0));
        step("mid_rel_e3", M_ALL, ev(1, 1, 0, 0, 0, 2'd0, 0));

        // DSACK_ deassert then reassert: one new pulse
        DSACK_ = 1'b1;
        step("ds_hi_e0", M_ALL, ev(1, 1, 0, 0, 0, 2'd0, 0));
        step("ds_hi_e1", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        DSACK_ = 1'b0;
        step("ds_lo_e0", M_ALL, ev(1, 1, 1, 0, 0, 2'd0, 0));
        step("ds_lo_e1", M_ALL, ev(1, 1, 0, 1, 0, 2'd0, 0));
        step("ds_lo_e2", M_ALL, ev(1, 1, 0, 0, 0, 2'd0, 0));

        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scsi_sm_input_cond.md
Name: scsi_sm_input_cond

Overview:
- Input-conditioning stage directly upstream of the SCSI state-machine input decode.
- Produces the synchronised/qualified terms that the decode consumes: CDREQ_, CDSACK_, CCPUREQ and BOEQ3.
- Synchronises the asynchronous SCSI-controller handshake lines and holds the pending CPU-access request flag.
- Maintains the 2-bit longword byte-offset pointer used to sequence byte transfers.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in each DREQ_/DSACK_ synchroniser. Legal values are 2 or 3; any other value is a synthesis error.

Ports:
CLK  in  1  system clock; all state updates on the rising edge
RST  in  1  synchronous reset, active-high
DREQ_  in  1  SCSI controller DMA request, active-low, asynchronous to CLK
DSACK_  in  1  SCSI controller data acknowledge, active-low, asynchronous to CLK
SET_CPUREQ  in  1  one-cycle pulse: host requests a CPU access to the SCSI controller
CLR_CPUREQ  in  1  one-cycle pulse from the SCSI SM: CPU access serviced
CLRBO  in  1  clear byte offset to 0
LOADBO  in  1  load byte offset from BO_IN
BO_IN  in  2  byte offset load value (transfer start address bits [1:0])
INCBO  in  1  advance byte offset by one
CDREQ_  out  1  synchronised DREQ_, active-low
CDSACK_  out  1  synchronised DSACK_, active-low
DSACK_FALL  out  1  one-cycle pulse on the synchronised assertion of DSACK_
CCPUREQ  out  1  registered pending CPU-request flag
BO  out  2  current byte offset
BOEQ3  out  1  high when BO == 3

Behaviour:
Reset (RST high at a rising edge), all registers are set as follows:
- Synchroniser chains are set to all ones, so CDREQ_=1 and CDSACK_=1.
- DSACK_FALL=0, CCPUREQ=0, BO=0, BOEQ3=0.
- Reset has priority over every other input, including mid-transfer and while a request is pending.

Synchronisers:
- Each of DREQ_ and DSACK_ passes through a SYNC_STAGES-deep chain; the last stage drives CDREQ_ and CDSACK_ respectively.
- A level change on DREQ_ or DSACK_ that is stable before edge N appears on the output after edge N+SYNC_STAGES-1.
- There is no combinational path from the async inputs to any output.

DSACK_FALL:
- A register holds the previous value of CDSACK_.
- DSACK_FALL=1 for exactly one cycle when previous CDSACK_=1 and current CDSACK_=0; it is 0 otherwise.
- A level held low gives exactly one pulse.
- The first cycle after reset never pulses, even if DSACK_ is already low, because the previous value resets to 1.

CPU-request flag (two states, IDLE (CCPUREQ=0) and PEND (CCPUREQ=1)):
- IDLE goes to PEND on SET_CPUREQ.
- PEND goes to IDLE on CLR_CPUREQ, unless SET_CPUREQ is also high.
- If SET_CPUREQ and CLR_CPUREQ are high in the same cycle, set wins: CCPUREQ is 1 next cycle, so a new request is never lost.
- SET_CPUREQ while already in PEND: no change; requests do not queue.
- CLR_CPUREQ while in IDLE: ignored.
- Latency: one edge from pulse to CCPUREQ change.

Byte-offset counter:
- Update priority: CLRBO > LOADBO > INCBO; if none is high, hold.
- CLRBO sets BO=0; LOADBO sets BO=BO_IN; INCBO sets BO=BO+1 modulo 4 (3 wraps to 0).
- All updates are registered, one-edge latency.
- BOEQ3 is decoded from the registered BO: same-cycle valid, glitch-free, with no path from the inputs.

Test Plan:
1. RST=1 for 2 cycles with DREQ_=0 and DSACK_=0 -> during reset CDREQ_=1, CDSACK_=1, CCPUREQ=0, BO=0, BOEQ3=0, DSACK_FALL=0. After release with SYNC_STAGES=2, CDREQ_ and CDSACK_ go 0 two edges later; DSACK_FALL pulses once, in the same cycle that CDSACK_ first reads 0.
2. DREQ_ toggled 1->0->1 with each level held for 5 cycles, run with SYNC_STAGES=2 and again with 3 -> CDREQ_ follows with exactly 2 (or 3) edges of delay. Random async jitter on DREQ_ never produces a one-cycle CDREQ_ glitch when the input is held for at least 3 cycles.
3. SET_CPUREQ pulse -> CCPUREQ=1 next cycle, held for 10 idle cycles. Then CLR_CPUREQ pulse -> CCPUREQ=0 next cycle. Then SET_CPUREQ and CLR_CPUREQ together from IDLE and again from PEND -> CCPUREQ=1 in both cases.
4. INCBO held for 6 cycles from BO=0 -> BO sequence 1,2,3,0,1,2. BOEQ3=1 only in the cycle BO=3.
5. LOADBO with BO_IN=2 and INCBO in the same cycle -> BO=2. Then CLRBO, LOADBO (BO_IN=3) and INCBO all together -> BO=0. Then LOADBO with BO_IN=3 -> BOEQ3=1 next cycle.
6. Reset mid-operation: BO=3, CCPUREQ=1, DSACK_ low -> RST pulse for 1 cycle -> BO=0, BOEQ3=0 and CCPUREQ=0 next cycle. CDSACK_ returns to 0 after SYNC_STAGES edges with a single DSACK_FALL pulse.
